// File: rtl/text_screen_sequencer.sv
// Screen-level sequencer for the text overlay: title menu with blinking cursor item,
// paced instruction reveal, and in-game HUD, all driving registered region enables.
module text_screen_sequencer #(
  parameter int unsigned REVEAL_FRAMES  = 30,
  parameter int unsigned BLINK_FRAMES   = 16,
  parameter int unsigned LOCKOUT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       hp_zero,
  output logic [1:0] screen,
  output logic       cursor_sel,
  output logic       start_text_en,
  output logic       howto_title_en,
  output logic [5:0] instr_line_en,
  output logic       hud_en,
  output logic       game_run,
  output logic       screen_changed
);

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_INSTR = 2'd1;
  localparam logic [1:0] SCR_PLAY  = 2'd2;

  localparam logic [7:0] LOCK_INIT   = 8'(LOCKOUT_FRAMES);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [5:0] ALL_LINES   = 6'h3F;

  logic [1:0] screen_q, screen_d;
  logic       cursor_q, cursor_d;
  logic       blink_on_q, blink_on_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic [7:0] reveal_cnt_q, reveal_cnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [5:0] instr_q, instr_d;
  logic       start_en_q, start_en_d;
  logic       howto_en_q, howto_en_d;
  logic       hud_q, hud_d;
  logic       run_q, run_d;
  logic       changed_q, changed_d;

  logic       accept;
  logic       go;
  logic [1:0] next_screen;

  always_comb begin
    screen_d     = screen_q;
    cursor_d     = cursor_q;
    blink_on_d   = blink_on_q;
    blink_cnt_d  = blink_cnt_q;
    reveal_cnt_d = reveal_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    instr_d      = instr_q;
    changed_d    = 1'b0;
    go           = 1'b0;
    next_screen  = screen_q;
    accept       = (lock_cnt_q == 8'd0);

    if (frame_tick && lock_cnt_q != 8'd0) lock_cnt_d = lock_cnt_q - 8'd1;

    case (screen_q)
      SCR_TITLE: begin
        if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
        // A cursor move restarts the blink so the newly selected item is visible at once
        if (accept && (btn_up ^ btn_down)) begin
          cursor_d    = ~cursor_q;
          blink_on_d  = 1'b1;
          blink_cnt_d = 8'd0;
        end
        if (accept && btn_select) begin
          go          = 1'b1;
          next_screen = cursor_q ? SCR_INSTR : SCR_PLAY;
        end
      end
      SCR_INSTR: begin
        if (frame_tick && instr_q != ALL_LINES) begin
          if (reveal_cnt_q == REVEAL_LAST) begin
            reveal_cnt_d = 8'd0;
            instr_d      = {instr_q[4:0], 1'b1};
          end else begin
            reveal_cnt_d = reveal_cnt_q + 8'd1;
          end
        end
        // First select completes the reveal; only a select on the full page leaves
        if (accept && btn_select) begin
          if (instr_q == ALL_LINES) begin
            go          = 1'b1;
            next_screen = SCR_TITLE;
          end else begin
            instr_d    = ALL_LINES;
            lock_cnt_d = LOCK_INIT;
          end
        end
      end
      SCR_PLAY: begin
        if (hp_zero) begin
          go          = 1'b1;
          next_screen = SCR_TITLE;
        end
      end
      default: begin
        go          = 1'b1;
        next_screen = SCR_TITLE;
      end
    endcase

    if (go) begin
      screen_d   = next_screen;
      lock_cnt_d = LOCK_INIT;
      changed_d  = 1'b1;
      if (next_screen == SCR_TITLE) begin
        cursor_d    = 1'b0;
        blink_on_d  = 1'b1;
        blink_cnt_d = 8'd0;
      end
      if (next_screen == SCR_INSTR) begin
        instr_d      = 6'b000001;
        reveal_cnt_d = 8'd0;
      end
    end

    if (screen_d != SCR_INSTR) instr_d = 6'd0;
    start_en_d = (screen_d == SCR_TITLE) & (cursor_d | blink_on_d);
    howto_en_d = (screen_d == SCR_TITLE) & (~cursor_d | blink_on_d);
    hud_d      = (screen_d == SCR_PLAY);
    run_d      = (screen_d == SCR_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_q     <= SCR_TITLE;
      cursor_q     <= 1'b0;
      blink_on_q   <= 1'b1;
      blink_cnt_q  <= 8'd0;
      reveal_cnt_q <= 8'd0;
      lock_cnt_q   <= LOCK_INIT;
      instr_q      <= 6'd0;
      start_en_q   <= 1'b1;
      howto_en_q   <= 1'b1;
      hud_q        <= 1'b0;
      run_q        <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      screen_q     <= screen_d;
      cursor_q     <= cursor_d;
      blink_on_q   <= blink_on_d;
      blink_cnt_q  <= blink_cnt_d;
      reveal_cnt_q <= reveal_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      instr_q      <= instr_d;
      start_en_q   <= start_en_d;
      howto_en_q   <= howto_en_d;
      hud_q        <= hud_d;
      run_q        <= run_d;
      changed_q    <= changed_d;
    end
  end

  assign screen         = screen_q;
  assign cursor_sel     = cursor_q;
  assign start_text_en  = start_en_q;
  assign howto_title_en = howto_en_q;
  assign instr_line_en  = instr_q;
  assign hud_en         = hud_q;
  assign game_run       = run_q;
  assign screen_changed = changed_q;

endmodule
